// File: rtl/rr_arbiter_8_if.sv
// Handshake bundle between the requester bank and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a bounded hold time and one dead cycle between grants.
// All outputs are registered; the one-hot grant is the decode of the winner index.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input logic           clk,
    input logic           rst,
    rr_arbiter_8_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q;
    logic [7:0]       grant_q;
    logic [2:0]       grant_idx_q;
    logic [2:0]       last_idx_q;
    logic             grant_valid_q;
    logic             timeout_q;
    logic [CNT_W-1:0] hold_cnt_q;

    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;
    logic       hold_max;
    logic       owner_req;
    logic       release_c;

    // Circular search starting just after the last owner; 3-bit add wraps mod 8.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        cand       = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_idx_q + 3'(k);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign hold_max  = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign owner_req = bus.req[grant_idx_q];
    assign release_c = bus.done || !owner_req || hold_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            grant_q       <= 8'd0;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
            last_idx_q    <= 3'd7;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_idx_q   <= pick_idx;
                        grant_q       <= 8'd1 << pick_idx;
                        grant_valid_q <= 1'b1;
                        hold_cnt_q    <= CNT_W'(1);
                        state_q       <= StGrant;
                    end
                end
                StGrant: begin
                    if (release_c) begin
                        grant_valid_q <= 1'b0;
                        grant_q       <= 8'd0;
                        last_idx_q    <= grant_idx_q;
                        hold_cnt_q    <= '0;
                        // Timeout flags only a release the owner did not ask for.
                        timeout_q     <= hold_max && owner_req && !bus.done;
                        state_q       <= StIdle;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (MAX_HOLD=4): expected outputs are queued
// as each cycle's stimulus is driven and popped once the edge has produced output.
module tb_rr_arbiter_8;
    logic clk;
    logic rst;

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp;
    int   n_bad;

    function automatic exp_t mk(input logic [7:0] g, input logic t);
        exp_t r;
        r.grant = g;
        r.valid = |g;
        r.to    = t;
        r.idx   = 3'd0;
        for (int b = 0; b < 8; b++) if (g[b]) r.idx = 3'(b);
        return r;
    endfunction

    // Apply one cycle of inputs and return just after the capturing edge.
    task automatic drive(input logic r, input logic [7:0] q, input logic d);
        rst      = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            sb.push_back(mk(8'h00, 1'b0));
            drive(1'b1, 8'hFF, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (bus.grant !== e.grant || bus.grant_valid !== e.valid || bus.timeout !== e.to) begin
                n_bad++;
                $display("FAIL reset c%0d: grant=%h valid=%b timeout=%b, required %h %b %b",
                         c, bus.grant, bus.grant_valid, bus.timeout, e.grant, e.valid, e.to);
            end
            n_cmp++;
            if (bus.grant_idx !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_idx c%0d: grant_idx=%0d, required 0", c, bus.grant_idx);
            end
        end
    endtask

    task automatic test_rotation();
        logic [7:0] eg[7] = '{8'h01, 8'h01, 8'h00, 8'h04, 8'h04, 8'h00, 8'h01};
        // done=1 at step 3 lands in IDLE and must be ignored
        logic       dn[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        sb.push_back(mk(8'h00, 1'b0));
        drive(1'b1, 8'h05, 1'b0);
        e = sb.pop_front();
        for (int c = 0; c < 7; c++) begin
            sb.push_back(mk(eg[c], 1'b0));
            drive(1'b0, 8'h05, dn[c]);
            e = sb.pop_front();
            n_cmp++;
            if (bus.grant !== e.grant || bus.grant_valid !== e.valid || bus.timeout !== e.to) begin
                n_bad++;
                $display("FAIL rotation c%0d: grant=%h valid=%b timeout=%b, required %h %b %b",
                         c, bus.grant, bus.grant_valid, bus.timeout, e.grant, e.valid, e.to);
            end
            if (e.valid) begin
                n_cmp++;
                if (bus.grant_idx !== e.idx) begin
                    n_bad++;
                    $display("FAIL rotation_idx c%0d: grant_idx=%0d, required %0d",
                             c, bus.grant_idx, e.idx);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g;
        sb.push_back(mk(8'h00, 1'b0));
        drive(1'b1, 8'hFF, 1'b1);
        e = sb.pop_front();
        for (int c = 0; c < 18; c++) begin
            g = 8'd1 << (c / 2) % 8;
            sb.push_back(mk((c % 2 == 0) ? g : 8'h00, 1'b0));
            drive(1'b0, 8'hFF, 1'b1);
            e = sb.pop_front();
            n_cmp++;
            if (bus.grant !== e.grant || bus.grant_valid !== e.valid || bus.timeout !== e.to) begin
                n_bad++;
                $display("FAIL b2b c%0d: grant=%h valid=%b timeout=%b, required %h %b %b",
                         c, bus.grant, bus.grant_valid, bus.timeout, e.grant, e.valid, e.to);
            end
            n_cmp++;
            if ($countones(bus.grant) > 1) begin
                n_bad++;
                $display("FAIL b2b_onehot c%0d: grant=%h, required at most one bit", c, bus.grant);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] eg[11] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08,
                               8'h08, 8'h08, 8'h08, 8'h00, 8'h08};
        logic       et[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // done arrives in the same cycle the hold limit is reached: normal release
        logic       dn[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sb.push_back(mk(8'h00, 1'b0));
        drive(1'b1, 8'h08, 1'b0);
        e = sb.pop_front();
        for (int c = 0; c < 11; c++) begin
            sb.push_back(mk(eg[c], et[c]));
            drive(1'b0, 8'h08, dn[c]);
            e = sb.pop_front();
            n_cmp++;
            if (bus.grant !== e.grant || bus.grant_valid !== e.valid || bus.timeout !== e.to) begin
                n_bad++;
                $display("FAIL timeout c%0d: grant=%h valid=%b timeout=%b, required %h %b %b",
                         c, bus.grant, bus.grant_valid, bus.timeout, e.grant, e.valid, e.to);
            end
        end
    endtask

    task automatic test_drop_req();
        logic [7:0] rq[5] = '{8'h82, 8'h83, 8'h83, 8'h80, 8'h80};
        logic [7:0] eg[5] = '{8'h02, 8'h02, 8'h02, 8'h00, 8'h80};
        sb.push_back(mk(8'h00, 1'b0));
        drive(1'b1, 8'h82, 1'b0);
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            sb.push_back(mk(eg[c], 1'b0));
            drive(1'b0, rq[c], 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (bus.grant !== e.grant || bus.grant_valid !== e.valid || bus.timeout !== e.to) begin
                n_bad++;
                $display("FAIL drop_req c%0d: grant=%h valid=%b timeout=%b, required %h %b %b",
                         c, bus.grant, bus.grant_valid, bus.timeout, e.grant, e.valid, e.to);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic       rs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] rq[4] = '{8'h20, 8'h20, 8'h21, 8'h21};
        logic [7:0] eg[4] = '{8'h20, 8'h20, 8'h00, 8'h01};
        sb.push_back(mk(8'h00, 1'b0));
        drive(1'b1, 8'h20, 1'b0);
        e = sb.pop_front();
        for (int c = 0; c < 4; c++) begin
            sb.push_back(mk(eg[c], 1'b0));
            drive(rs[c], rq[c], 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (bus.grant !== e.grant || bus.grant_valid !== e.valid || bus.timeout !== e.to) begin
                n_bad++;
                $display("FAIL mid_reset c%0d: grant=%h valid=%b timeout=%b, required %h %b %b",
                         c, bus.grant, bus.grant_valid, bus.timeout, e.grant, e.valid, e.to);
            end
            if (e.valid) begin
                n_cmp++;
                if (bus.grant_idx !== e.idx) begin
                    n_bad++;
                    $display("FAIL mid_reset_idx c%0d: grant_idx=%0d, required %0d",
                             c, bus.grant_idx, e.idx);
                end
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        n_cmp    = 0;
        n_bad    = 0;
        test_reset();
        test_rotation();
        test_back_to_back();
        test_timeout();
        test_drop_req();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
